// File: rtl/mips_instr_rom_loader_if.sv
// Byte-stream loader handshake: the program source drives valid/byte/last,
// and the ROM loader returns ready.
interface mips_instr_rom_loader_if;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] load_byte;
    logic       load_last;

    modport master (output load_valid, load_byte, load_last, input  load_ready);
    modport slave  (input  load_valid, load_byte, load_last, output load_ready);
endinterface

// File: rtl/mips_instr_rom_loader.sv
// Instruction ROM fed by a byte-stream loader. It holds the CPU in reset until the program is loaded.
// Define MIPS_ROM_BYTESWAP_EN to present the read word lane-swapped for mips_cpu_harvard.
module mips_instr_rom_loader #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter int          DEPTH_WORDS  = 256
) (
    input  logic                         clk,
    input  logic                         reset,
    mips_instr_rom_loader_if.slave       ld,
    output logic                         load_done,
    output logic                         load_error,
    output logic                         cpu_reset,
    output logic [$clog2(DEPTH_WORDS):0] word_count,
    input  logic [31:0]                  instr_address,
    output logic [31:0]                  instr_readdata
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_LOAD, S_RUN, S_ERROR} state_t;

    state_t      state;
    logic [1:0]  byte_cnt;
    logic [31:0] shreg;
    logic [31:0] mem [DEPTH_WORDS];

    logic        xfer, full, mem_we;
    logic [31:0] next_sh, wdata;
    logic [4:0]  pad_sh;

    assign xfer    = (state == S_LOAD) && ld.load_valid && ld.load_ready;
    assign full    = (word_count == CW'(DEPTH_WORDS));
    assign mem_we  = xfer && !full && (byte_cnt == 2'd3 || ld.load_last);
    assign next_sh = {shreg[23:0], ld.load_byte};
    // A partial final word is left-justified; the shift pads the low bytes with zeros.
    assign pad_sh  = {2'd3 - byte_cnt, 3'b000};
    assign wdata   = next_sh << pad_sh;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_LOAD;
            ld.load_ready <= 1'b1;
            load_done     <= 1'b0;
            load_error    <= 1'b0;
            cpu_reset     <= 1'b1;
            word_count    <= '0;
            byte_cnt      <= 2'd0;
            shreg         <= 32'h0;
        end else begin
            case (state)
                S_LOAD: if (xfer) begin
                    if (full) begin
                        state         <= S_ERROR;
                        ld.load_ready <= 1'b0;
                        load_error    <= 1'b1;
                    end else if (mem_we) begin
                        word_count <= word_count + CW'(1);
                        byte_cnt   <= 2'd0;
                        shreg      <= 32'h0;
                        if (ld.load_last) begin
                            state         <= S_RUN;
                            ld.load_ready <= 1'b0;
                            load_done     <= 1'b1;
                            cpu_reset     <= 1'b0;
                        end
                    end else begin
                        byte_cnt <= byte_cnt + 2'd1;
                        shreg    <= next_sh;
                    end
                end
                default: ;
            endcase
        end
    end

    // Contents survive reset; word_count alone decides what is readable.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[word_count[AW-1:0]] <= wdata;
    end

    logic [31:0] off, word;

    always_comb begin
        off  = (instr_address - RESET_VECTOR) >> 2;
        word = 32'h0;
        if (instr_address[1:0] == 2'b00 && instr_address >= RESET_VECTOR &&
            off < 32'(word_count))
            word = mem[off[AW-1:0]];
    end

`ifdef MIPS_ROM_BYTESWAP_EN
    assign instr_readdata = {word[7:0], word[15:8], word[23:16], word[31:24]};
`else
    assign instr_readdata = word;
`endif
endmodule
